// File: rtl/out_vc_alloc.sv
// Output-port VC allocator: binds each packet to a free downstream VC, drives the
// one-hot selOutVC for the head-flit encoder, and gates flits on per-VC credits.
//
// state  | meaning
// IDLE   | no VC bound; a HEAD at the input is allocated a free VC
// ACTIVE | packet bound to cur_vc; flits forwarded while credits remain, until TAIL

module out_vc_alloc #(
    parameter int         V         = 4,
    parameter int         DW        = 16,
    parameter int         BUF_DEPTH = 4,
    parameter logic [1:0] HEAD      = 2'b01,
    parameter logic [1:0] TAIL      = 2'b11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flit_valid_i,
    input  logic [DW-1:0] flit_i,
    output logic          flit_ready_o,
    output logic          flit_valid_o,
    output logic [DW-1:0] flit_o,
    output logic [V-1:0]  selOutVC,
    input  logic [V-1:0]  credit_i,
    output logic          err_o
);

    localparam int            CW   = $clog2(BUF_DEPTH + 1);
    localparam int            IW   = (V > 1) ? $clog2(V) : 1;
    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q [V];
    logic [CW-1:0] cnt_d [V];
    logic [V-1:0]  busy_q, busy_d;
    logic [V-1:0]  cur_vc_q, cur_vc_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic          first_q, first_d;

    logic          is_head, is_tail;
    logic [V-1:0]  free_vc, has_credit, alloc, sent, credit_err;
    logic          grant_found;
    logic [IW-1:0] grant_idx, cur_idx;
    logic          cur_has_credit, xfer, proto_err;

    assign flit_o  = flit_i;
    assign is_head = (flit_i[DW-1:DW-2] == HEAD);
    assign is_tail = (flit_i[DW-1:DW-2] == TAIL);

    always_comb begin
        free_vc    = '0;
        has_credit = '0;
        cur_idx    = '0;
        for (int v = 0; v < V; v++) begin
            free_vc[v]    = !busy_q[v] && (cnt_q[v] == FULL);
            has_credit[v] = (cnt_q[v] != '0);
            if (cur_vc_q[v]) cur_idx = IW'(v);
        end
        cur_has_credit = |(cur_vc_q & has_credit);
    end

    // Rotating-priority search for a fully credited, unreserved VC.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < V; i++) begin
            if (!grant_found && free_vc[(int'(rr_ptr_q) + i) % V]) begin
                grant_found = 1'b1;
                grant_idx   = IW'((int'(rr_ptr_q) + i) % V);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        cur_vc_d = cur_vc_q;
        rr_ptr_d = rr_ptr_q;
        first_d  = first_q;
        alloc    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (flit_valid_i && is_head && grant_found) begin
                    for (int v = 0; v < V; v++) alloc[v] = (grant_idx == IW'(v));
                    cur_vc_d = alloc;
                    first_d  = 1'b1;
                    state_d  = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (xfer) first_d = 1'b0;
                if (xfer && is_tail) begin
                    state_d  = S_IDLE;
                    cur_vc_d = '0;
                    rr_ptr_d = (cur_idx == IW'(V - 1)) ? '0 : cur_idx + IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        flit_ready_o = 1'b0;
        flit_valid_o = 1'b0;
        selOutVC     = '0;
        xfer         = 1'b0;
        proto_err    = 1'b0;
        if (!rst) begin
            unique case (state_q)
                S_IDLE: begin
                    if (flit_valid_i && !is_head) begin
                        flit_ready_o = 1'b1;
                        proto_err    = 1'b1;
                    end
                end
                S_ACTIVE: begin
                    selOutVC     = cur_vc_q;
                    flit_ready_o = cur_has_credit;
                    flit_valid_o = flit_valid_i && cur_has_credit;
                    xfer         = flit_valid_i && cur_has_credit;
                    proto_err    = xfer && is_head && !first_q;
                end
                default: ;
            endcase
        end
    end

    // A VC stays reserved until all its slots are credited back and it is no longer bound.
    always_comb begin
        sent       = '0;
        credit_err = '0;
        busy_d     = '0;
        for (int v = 0; v < V; v++) begin
            sent[v]       = xfer && cur_vc_q[v];
            credit_err[v] = credit_i[v] && !sent[v] && (cnt_q[v] == FULL);
            cnt_d[v]      = cnt_q[v];
            if (credit_i[v] && !sent[v] && !credit_err[v]) cnt_d[v] = cnt_q[v] + CW'(1);
            else if (sent[v] && !credit_i[v])              cnt_d[v] = cnt_q[v] - CW'(1);
            busy_d[v] = alloc[v] || (busy_q[v] && !((cnt_d[v] == FULL) && !cur_vc_d[v]));
        end
    end

    assign err_o = !rst && (proto_err || (|credit_err));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            cur_vc_q <= '0;
            rr_ptr_q <= '0;
            first_q  <= 1'b0;
            for (int v = 0; v < V; v++) cnt_q[v] <= FULL;
        end else begin
            busy_q   <= busy_d;
            cur_vc_q <= cur_vc_d;
            rr_ptr_q <= rr_ptr_d;
            first_q  <= first_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
